// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, flush-to-bubble,
// optional 2-entry skid buffer and a saturating output-stall counter.
module pipe_stage_skid #(
  parameter int unsigned CTRL_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 160,
  parameter bit          SKID_EN    = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [CTRL_WIDTH-1:0] in_ctrl_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CTRL_WIDTH-1:0] out_ctrl_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [CNT_WIDTH-1:0]  stall_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Bit 0 is the main-entry valid, bit 1 the skid-entry valid.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'b00,
    OCC_ONE   = 2'b01,
    OCC_TWO   = 2'b11
  } occ_e;

  occ_e                  occ_q, occ_d;
  logic [CTRL_WIDTH-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [CTRL_WIDTH-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_WIDTH-1:0] s_data_q, s_data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  in_ready_c;
  logic                  accept_c;
  logic                  pop_c;

  // Ready: registered (skid free) with the buffer, else pass-through of out_ready_i.
  always_comb begin
    if (SKID_EN) begin
      in_ready_c = ~occ_q[1];
    end else begin
      in_ready_c = ~occ_q[0] | out_ready_i;
    end
    accept_c = in_valid_i & in_ready_c;
    pop_c    = occ_q[0] & out_ready_i;
  end

  // Occupancy next-state and entry loading; flush overrides every transition.
  always_comb begin
    occ_d    = occ_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;
    if (flush_i) begin
      occ_d    = OCC_EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept_c) begin
            occ_d    = OCC_ONE;
            m_ctrl_d = in_ctrl_i;
            m_data_d = in_data_i;
          end
        end
        OCC_ONE: begin
          if (pop_c && accept_c) begin
            m_ctrl_d = in_ctrl_i;
            m_data_d = in_data_i;
          end else if (pop_c) begin
            occ_d    = OCC_EMPTY;
            m_ctrl_d = '0;
          end else if (accept_c && SKID_EN) begin
            occ_d    = OCC_TWO;
            s_ctrl_d = in_ctrl_i;
            s_data_d = in_data_i;
          end
        end
        OCC_TWO: begin
          if (pop_c) begin
            occ_d    = OCC_ONE;
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
            s_ctrl_d = '0;
          end
        end
        default: begin
          occ_d    = OCC_EMPTY;
          m_ctrl_d = '0;
          s_ctrl_d = '0;
        end
      endcase
    end
  end

  // Saturating count of cycles where the head is held by downstream.
  always_comb begin
    cnt_d = cnt_q;
    if (occ_q[0] && !out_ready_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // State and payload registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q    <= OCC_EMPTY;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
      cnt_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready_o  = in_ready_c;
  assign out_valid_o = occ_q[0];
  assign out_ctrl_o  = m_ctrl_q;
  assign out_data_o  = m_data_q;
  assign stall_cnt_o = cnt_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three instances (skid, no-skid, skid with 3-bit
// counter) share one stimulus stream and are each compared to a FIFO model.
module tb_pipe_stage_skid;

  logic         clk = 1'b0;
  logic         rstn;
  logic         flush;
  logic         in_valid;
  logic [5:0]   in_ctrl;
  logic [159:0] in_data;
  logic         out_ready;

  logic         ir   [3];
  logic         ov   [3];
  logic [5:0]   oc   [3];
  logic [159:0] od   [3];
  logic [15:0]  sc0, sc1;
  logic [2:0]   sc2;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: up to two queued entries per instance, index 0 is the head.
  logic [5:0]   q_ctrl [3][2];
  logic [159:0] q_data [3][2];
  int           q_cnt  [3];
  logic [159:0] q_last [3];
  int           q_stall[3];
  bit           q_skid [3];
  int           q_max  [3];

  always #5 clk = ~clk;

  pipe_stage_skid #(.SKID_EN(1'b1), .CNT_WIDTH(16)) u_skid (
    .clk(clk), .rstn(rstn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir[0]),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(ov[0]), .out_ready_i(out_ready),
    .out_ctrl_o(oc[0]), .out_data_o(od[0]), .stall_cnt_o(sc0));

  pipe_stage_skid #(.SKID_EN(1'b0), .CNT_WIDTH(16)) u_noskid (
    .clk(clk), .rstn(rstn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir[1]),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(ov[1]), .out_ready_i(out_ready),
    .out_ctrl_o(oc[1]), .out_data_o(od[1]), .stall_cnt_o(sc1));

  pipe_stage_skid #(.SKID_EN(1'b1), .CNT_WIDTH(3)) u_sat (
    .clk(clk), .rstn(rstn), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(ir[2]),
    .in_ctrl_i(in_ctrl), .in_data_i(in_data), .out_valid_o(ov[2]), .out_ready_i(out_ready),
    .out_ctrl_o(oc[2]), .out_data_o(od[2]), .stall_cnt_o(sc2));

  task automatic chk(input string tag, input int i, input logic [159:0] obs,
                     input logic [159:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s[%0d] observed=%h expected=%h", tag, i, obs, exp);
  endtask

  function automatic logic model_ready(input int i, input logic ordy);
    if (q_skid[i]) return (q_cnt[i] < 2);
    return (q_cnt[i] == 0) || ordy;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      q_cnt[i]   = 0;
      q_last[i]  = '0;
      q_stall[i] = 0;
    end
  endtask

  task automatic model_edge(input int i, input logic f, input logic acc, input logic ordy,
                            input logic [5:0] c, input logic [159:0] d);
    logic pp;
    pp = (q_cnt[i] > 0) && ordy;
    if ((q_cnt[i] > 0) && !ordy && (q_stall[i] < q_max[i])) q_stall[i]++;
    if (f) begin
      q_cnt[i] = 0;
    end else begin
      if (pp) begin
        q_ctrl[i][0] = q_ctrl[i][1];
        q_data[i][0] = q_data[i][1];
        q_cnt[i]--;
      end
      if (acc) begin
        q_ctrl[i][q_cnt[i]] = c;
        q_data[i][q_cnt[i]] = d;
        q_cnt[i]++;
      end
    end
    if (q_cnt[i] > 0) q_last[i] = q_data[i][0];
  endtask

  task automatic check_outputs();
    logic [15:0] s;
    for (int i = 0; i < 3; i++) begin
      s = (i == 0) ? sc0 : (i == 1) ? sc1 : 16'(sc2);
      chk("out_valid", i, 160'(ov[i]), 160'(q_cnt[i] > 0));
      chk("out_ctrl",  i, 160'(oc[i]), (q_cnt[i] > 0) ? 160'(q_ctrl[i][0]) : 160'd0);
      chk("out_data",  i, od[i], q_last[i]);
      chk("stall_cnt", i, 160'(s), 160'(q_stall[i]));
    end
  endtask

  // One clock cycle: drive, check ready, advance model at the edge, check outputs.
  task automatic step(input logic f, input logic iv, input logic [5:0] c,
                      input logic [159:0] d, input logic ordy);
    logic acc [3];
    flush     = f;
    in_valid  = iv;
    in_ctrl   = c;
    in_data   = d;
    out_ready = ordy;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("in_ready", i, 160'(ir[i]), 160'(model_ready(i, ordy)));
      acc[i] = iv && model_ready(i, ordy);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_edge(i, f, acc[i], ordy, c, d);
    #1;
    check_outputs();
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic async_reset();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    for (int i = 0; i < 3; i++) chk("rst_in_ready", i, 160'(ir[i]), 160'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
  endtask

  function automatic logic [159:0] rnd160();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    q_skid = '{1'b1, 1'b0, 1'b1};
    q_max  = '{65535, 65535, 7};
    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_outputs();
    for (int i = 0; i < 3; i++) chk("rst_in_ready", i, 160'(ir[i]), 160'd1);
    rstn = 1'b1;

    // Streaming at full rate.
    for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 6'h21, 160'(8'h11 + k), 1'b1);
    step(1'b0, 1'b0, 6'h00, '0, 1'b1);
    step(1'b0, 1'b0, 6'h00, '0, 1'b1);

    // Backpressure fill, blocked input, then drain in order.
    step(1'b0, 1'b1, 6'h05, 160'h0A0, 1'b0);
    step(1'b0, 1'b1, 6'h06, 160'h0B0, 1'b0);
    step(1'b0, 1'b1, 6'h07, 160'h0C0, 1'b0);
    step(1'b0, 1'b0, 6'h00, '0, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 6'h00, '0, 1'b1);

    // Flush while full with a blocked input, then flush while accepting.
    step(1'b0, 1'b1, 6'h11, 160'h1, 1'b0);
    step(1'b0, 1'b1, 6'h12, 160'h2, 1'b0);
    step(1'b1, 1'b1, 6'h13, 160'h3, 1'b0);
    step(1'b0, 1'b1, 6'h14, 160'h4, 1'b0);
    step(1'b1, 1'b1, 6'h15, 160'h5, 1'b1);
    step(1'b0, 1'b0, 6'h00, '0, 1'b1);

    // Continuous input with alternating downstream ready, items 0..7.
    for (int k = 0; k < 8; k++) step(1'b0, 1'b1, 6'h3F, 160'(k), (k % 2) == 0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 6'h00, '0, 1'b1);

    // Long stall: 3-bit counter saturates at 7 and holds.
    step(1'b0, 1'b1, 6'h2A, 160'h77, 1'b0);
    for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 6'h00, '0, 1'b0);
    step(1'b0, 1'b0, 6'h00, '0, 1'b1);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 15) == 0), $urandom_range(0, 1) == 1, 6'($urandom()),
           rnd160(), ($urandom_range(0, 3) != 0));
    end

    // Reset mid-stall with two entries held.
    async_reset();
    step(1'b0, 1'b1, 6'h01, 160'hAA, 1'b0);
    step(1'b0, 1'b1, 6'h02, 160'hBB, 1'b0);
    for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 6'h00, '0, 1'b0);
    async_reset();
    step(1'b0, 1'b1, 6'h03, 160'hCC, 1'b1);
    step(1'b0, 1'b0, 6'h00, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
